// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the two-port data-memory arbiter: both requester ports, the
// memory-side port and the contention counter.
// slave  : the arbiter's view.
// master : the environment's view (requesters plus the data memory).
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  // Requester port 0
  logic                  req0;
  logic                  lock0;
  logic                  we0;
  logic [DATA_WIDTH-1:0] a0;
  logic [DATA_WIDTH-1:0] wd0;
  logic                  gnt0;
  logic [DATA_WIDTH-1:0] rd0;
  logic                  valid0;

  // Requester port 1
  logic                  req1;
  logic                  lock1;
  logic                  we1;
  logic [DATA_WIDTH-1:0] a1;
  logic [DATA_WIDTH-1:0] wd1;
  logic                  gnt1;
  logic [DATA_WIDTH-1:0] rd1;
  logic                  valid1;

  // Data-memory side
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;

  // Contention statistics
  logic [15:0]           conflict_cnt;

  modport slave (
    input  req0, lock0, we0, a0, wd0,
    input  req1, lock1, we1, a1, wd1,
    input  mem_rd,
    output gnt0, rd0, valid0,
    output gnt1, rd1, valid1,
    output mem_we, mem_a, mem_wd,
    output conflict_cnt
  );

  modport master (
    output req0, lock0, we0, a0, wd0,
    output req1, lock1, we1, a1, wd1,
    output mem_rd,
    input  gnt0, rd0, valid0,
    input  gnt1, rd1, valid1,
    input  mem_we, mem_a, mem_wd,
    input  conflict_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter.
// - Alternating priority on ties, steered by the index of the last granted port.
// - A port holding LOCK keeps ownership for up to MAX_HOLD back-to-back
//   grants. It yields only when the other port is waiting.
// - Read data is captured into a per-port register. A one-cycle VALID pulse
//   marks each new value.
// Optional feature: define DMEM_ARB_CONFLICT_CNT_EN to build the saturating
// contention counter. Without it conflict_cnt is tied to zero.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 8    // legal range 2..255
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t                state;
  state_t                state_nxt;
  logic                  last;       // index of the most recently granted port
  logic                  last_nxt;
  logic [7:0]            hold_cnt;   // consecutive grants to the owning port
  logic [7:0]            hold_nxt;

  logic                  gnt0_c;
  logic                  gnt1_c;
  logic                  idle_gnt0;
  logic                  idle_gnt1;
  logic                  use_idle_arb;

  logic [DATA_WIDTH-1:0] rd0_q;
  logic [DATA_WIDTH-1:0] rd1_q;
  logic                  valid0_q;
  logic                  valid1_q;

  // Unlocked arbitration: a lone requester wins. On a tie, the port that was
  // not granted last wins. LAST resets to 1, so port 0 takes the first tie.
  assign idle_gnt0 = bus.req0 & (~bus.req1 | last);
  assign idle_gnt1 = bus.req1 & (~bus.req0 | ~last);

  // Grant selection and next ownership state.
  // NOTE: every variable assigned here gets a default first. A path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_cnt;
    gnt0_c       = 1'b0;
    gnt1_c       = 1'b0;
    use_idle_arb = 1'b0;

    case (state)
      IDLE: use_idle_arb = 1'b1;

      OWN0: begin
        if (!bus.req0) begin
          // The owner went quiet, so arbitrate this cycle as if unlocked.
          use_idle_arb = 1'b1;
        end else if (hold_cnt < MAX_HOLD_C) begin
          gnt0_c    = 1'b1;
          state_nxt = bus.lock0 ? OWN0 : IDLE;
          hold_nxt  = bus.lock0 ? hold_cnt + 8'd1 : 8'd0;
        end else if (bus.req1) begin
          // The hold budget is spent and port 1 is waiting, so it takes over.
          gnt1_c    = 1'b1;
          state_nxt = bus.lock1 ? OWN1 : IDLE;
          hold_nxt  = bus.lock1 ? 8'd1 : 8'd0;
        end else begin
          // Nobody else wants the memory. The owner keeps it and the count
          // stays saturated.
          gnt0_c    = 1'b1;
          state_nxt = bus.lock0 ? OWN0 : IDLE;
          hold_nxt  = bus.lock0 ? hold_cnt : 8'd0;
        end
      end

      OWN1: begin
        if (!bus.req1) begin
          use_idle_arb = 1'b1;
        end else if (hold_cnt < MAX_HOLD_C) begin
          gnt1_c    = 1'b1;
          state_nxt = bus.lock1 ? OWN1 : IDLE;
          hold_nxt  = bus.lock1 ? hold_cnt + 8'd1 : 8'd0;
        end else if (bus.req0) begin
          gnt0_c    = 1'b1;
          state_nxt = bus.lock0 ? OWN0 : IDLE;
          hold_nxt  = bus.lock0 ? 8'd1 : 8'd0;
        end else begin
          gnt1_c    = 1'b1;
          state_nxt = bus.lock1 ? OWN1 : IDLE;
          hold_nxt  = bus.lock1 ? hold_cnt : 8'd0;
        end
      end

      default: begin
        state_nxt = IDLE;
        hold_nxt  = 8'd0;
      end
    endcase

    if (use_idle_arb) begin
      gnt0_c = idle_gnt0;
      gnt1_c = idle_gnt1;
      if (idle_gnt0 && bus.lock0) begin
        state_nxt = OWN0;
        hold_nxt  = 8'd1;
      end else if (idle_gnt1 && bus.lock1) begin
        state_nxt = OWN1;
        hold_nxt  = 8'd1;
      end else begin
        state_nxt = IDLE;
        hold_nxt  = 8'd0;
      end
    end

    // Grants are combinational, so reset must suppress them directly rather
    // than wait for the state register.
    if (rst) begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
    end
  end

  assign last_nxt = gnt0_c ? 1'b0 : (gnt1_c ? 1'b1 : last);

  // Arbiter state: ownership, hold counter and last-granted index.
  // NOTE: sequential state uses non-blocking assignments. All flops update
  // together from pre-edge values, with no ordering races between blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Memory request mux. The bus stays all-zero when no port is granted.
  assign bus.mem_we = (gnt0_c & bus.we0) | (gnt1_c & bus.we1);
  assign bus.mem_a  = gnt0_c ? bus.a0  : (gnt1_c ? bus.a1  : '0);
  assign bus.mem_wd = gnt0_c ? bus.wd0 : (gnt1_c ? bus.wd1 : '0);

  // Read-data capture at the grant edge. VALID marks the cycle after a read.
  // NOTE: the read-data registers are cleared on reset because a stale RD
  // must not survive reset. The data memory itself lives outside this block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0_q    <= '0;
      rd1_q    <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      valid0_q <= gnt0_c & ~bus.we0;
      valid1_q <= gnt1_c & ~bus.we1;
      if (gnt0_c && !bus.we0) rd0_q <= bus.mem_rd;
      if (gnt1_c && !bus.we1) rd1_q <= bus.mem_rd;
    end
  end

  assign bus.gnt0   = gnt0_c;
  assign bus.gnt1   = gnt1_c;
  assign bus.rd0    = rd0_q;
  assign bus.rd1    = rd1_q;
  assign bus.valid0 = valid0_q;
  assign bus.valid1 = valid1_q;

`ifdef DMEM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_q;

  // Count cycles in which both ports request, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= 16'd0;
    end else if (bus.req0 && bus.req1 && conflict_q != 16'hFFFF) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign bus.conflict_cnt = conflict_q;
`else
  assign bus.conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// - A 16-word data memory is attached to the memory port.
// - A behavioural model tracks owner, streak and last grant, and is compared
//   against the DUT every cycle.
// - Directed scenarios pin the model with literal expectations.
// - Random traffic then follows, obeying the hold-until-granted rule.
module tb_dmem_arbiter;
  localparam int DW       = 32;
  localparam int MAX_HOLD = 8;
`ifdef DMEM_ARB_CONFLICT_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  dmem_arbiter #(.DATA_WIDTH(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Data memory: combinational read, write at the clock edge.
  logic [31:0] mem [16];
  assign bus.mem_rd = mem[bus.mem_a[3:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[3:0]] <= bus.mem_wd;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  int          m_owner;    // port holding a lock, -1 when none
  int          m_streak;   // grants in the current locked run
  int          m_last;
  int          m_cnt;
  logic [31:0] m_rd [2];
  bit          m_valid [2];
  logic [31:0] ref_mem [16];

  task automatic model_reset();
    m_owner  = -1;
    m_streak = 0;
    m_last   = 1;
    m_cnt    = 0;
    m_rd[0]  = '0;
    m_rd[1]  = '0;
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
  endtask

  task automatic drive(input int p, input bit rq, input bit lk, input bit w,
                       input logic [31:0] ad, input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = rq; bus.lock0 = lk; bus.we0 = w; bus.a0 = ad; bus.wd0 = d;
    end else begin
      bus.req1 = rq; bus.lock1 = lk; bus.we1 = w; bus.a1 = ad; bus.wd1 = d;
    end
  endtask

  // One clock cycle. Inputs are set by the caller after a falling edge.
  // The task compares every DUT output against the model, advances the model
  // at the rising edge and returns the expected grant (-1 = none).
  // rst_after asserts reset just after the rising edge.
  task automatic tick(input bit rst_after, output int g);
    bit          r [2];
    bit          l [2];
    bit          w [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    int          fresh;
    int          n;
    int          nown;
    int          nstr;
    #1;
    r[0] = bus.req0;  r[1] = bus.req1;
    l[0] = bus.lock0; l[1] = bus.lock1;
    w[0] = bus.we0;   w[1] = bus.we1;
    a[0] = bus.a0;    a[1] = bus.a1;
    d[0] = bus.wd0;   d[1] = bus.wd1;

    fresh = (r[0] && r[1]) ? 1 - m_last : (r[0] ? 0 : (r[1] ? 1 : -1));
    if (rst) g = -1;
    else if (m_owner < 0) g = fresh;
    else begin
      n = m_owner;
      if (!r[n]) g = fresh;
      else if (m_streak < MAX_HOLD) g = n;
      else if (r[1-n]) g = 1 - n;
      else g = n;
    end

    check("gnt0",   32'(bus.gnt0),   32'(g == 0));
    check("gnt1",   32'(bus.gnt1),   32'(g == 1));
    check("mem_we", 32'(bus.mem_we), 32'(g >= 0 && w[g]));
    check("mem_a",  bus.mem_a,  (g >= 0) ? a[g] : 32'h0);
    check("mem_wd", bus.mem_wd, (g >= 0) ? d[g] : 32'h0);
    check("rd0",    bus.rd0, m_rd[0]);
    check("rd1",    bus.rd1, m_rd[1]);
    check("valid0", 32'(bus.valid0), 32'(m_valid[0]));
    check("valid1", 32'(bus.valid1), 32'(m_valid[1]));
    check("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_cnt));

    @(posedge clk);
    if (rst_after) begin
      #1;
      rst = 1'b1;
      model_reset();
    end else if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_valid[k] = (g == k) && !w[k];
        if (m_valid[k]) m_rd[k] = ref_mem[a[k][3:0]];
      end
      if (g >= 0 && w[g]) ref_mem[a[g][3:0]] = d[g];
      if (CNT_ON == 1 && r[0] && r[1] && m_cnt < 65535) m_cnt++;
      if (g >= 0) begin
        nown = l[g] ? g : -1;
        if (!l[g]) nstr = 0;
        else if (g == m_owner) nstr = (m_streak < MAX_HOLD) ? m_streak + 1 : MAX_HOLD;
        else nstr = 1;
        m_last = g;
      end else begin
        nown = -1;
        nstr = 0;
      end
      m_owner  = nown;
      m_streak = nstr;
    end
    @(negedge clk);
  endtask

  initial begin
    int  g;
    bit  pend [2];
    bit  rq [2];
    bit  wr [2];
    logic [31:0] ad [2];
    logic [31:0] dt [2];
    int  bias;

    for (int i = 0; i < 16; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    rst = 1'b1;
    // Requests are already high during reset. Grants must stay suppressed.
    drive(0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
    drive(1, 1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
    @(negedge clk);
    #1;
    check("rst_gnt0",   32'(bus.gnt0),   32'd0);
    check("rst_gnt1",   32'(bus.gnt1),   32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_rd0",    bus.rd0, 32'd0);
    check("rst_valid0", 32'(bus.valid0), 32'd0);
    check("rst_cnt",    32'(bus.conflict_cnt), 32'd0);
    tick(1'b0, g);

    // Tie released from reset: port 0 first, then alternation.
    rst = 1'b0;
    tick(1'b0, g); check("alt_c1", 32'(g), 32'd0);
    tick(1'b0, g); check("alt_c2", 32'(g), 32'd1);
    check("alt_cnt2", 32'(bus.conflict_cnt), 32'(2 * CNT_ON));
    tick(1'b0, g); check("alt_c3", 32'(g), 32'd0);
    tick(1'b0, g); check("alt_c4", 32'(g), 32'd1);

    // Port 1 writes, then port 0 reads the same word back.
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b1, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
    tick(1'b0, g); check("wr_gnt1", 32'(g), 32'd1);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    tick(1'b0, g); check("rd_gnt0", 32'(g), 32'd0);
    check("rd0_data",  bus.rd0, 32'hDEADBEEF);
    check("rd0_valid", 32'(bus.valid0), 32'd1);
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(1'b0, g);
    check("rd0_valid_drop", 32'(bus.valid0), 32'd0);
    check("rd0_hold", bus.rd0, 32'hDEADBEEF);

    // Locked port 0 against a waiting port 1. LAST is 0 here, so port 1 wins
    // the first tie. Then port 0 gets eight grants and port 1 the ninth.
    drive(0, 1'b1, 1'b1, 1'b0, 32'd3, 32'd0);
    drive(1, 1'b1, 1'b0, 1'b0, 32'd4, 32'd0);
    tick(1'b0, g); check("lock_pre", 32'(g), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, g); check("lock_run", 32'(g), 32'd0);
    end
    tick(1'b0, g); check("lock_yield", 32'(g), 32'd1);

    // Locked port 0 alone for 20 cycles, then port 1 must win at once.
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, g); check("sat_run", 32'(g), 32'd0);
    end
    drive(1, 1'b1, 1'b0, 1'b0, 32'd6, 32'd0);
    tick(1'b0, g); check("sat_yield", 32'(g), 32'd1);

    // Reset right after a read grant kills the pending VALID.
    drive(0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(1'b1, g); check("mid_gnt0", 32'(g), 32'd0);
    check("mid_valid0", 32'(bus.valid0), 32'd0);
    check("mid_rd0",    bus.rd0, 32'd0);
    check("mid_mem_we", 32'(bus.mem_we), 32'd0);
    check("mid_gnt0_rst", 32'(bus.gnt0), 32'd0);
    tick(1'b0, g);
    rst = 1'b0;
    drive(1, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0);
    tick(1'b0, g); check("post_rst_tie", 32'(g), 32'd0);

    // Randomized traffic obeying the hold-until-granted rule.
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(1'b0, g);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bias = (i < 1500) ? 60 : 90;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          rq[p] = ($urandom_range(0, 99) < bias);
          wr[p] = $urandom_range(0, 1) == 1;
          ad[p] = 32'($urandom_range(0, 15));
          dt[p] = $urandom;
        end
        drive(p, rq[p], ($urandom_range(0, 99) < 60), wr[p], ad[p], dt[p]);
      end
      tick(1'b0, g);
      pend[0] = rq[0] && (g != 0);
      pend[1] = rq[1] && (g != 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
